pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage rv32i pipeline.
- Drives load enables for PC, IF_ID, ID_EX, EX_MEM and MEM_WB, plus flush controls for IF_ID and ID_EX.
- Resolves three hazard sources with a fixed priority: memory stalls (I-cache/D-cache response wait), EX-stage control redirects, and load-use data hazards.
- Sits beside the datapath in the CPU top; pipeline registers take `load` and `flush` from this block only.

---
 rtl/rv32i_types.sv | 13 +
 rtl/pipeline_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: stall/flush sequencer states and PC mux selects.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BUBBLE   = 2'd2
  } pipe_ctrl_state_t;

  localparam logic PCSEL_PLUS4    = 1'b0;
  localparam logic PCSEL_REDIRECT = 1'b1;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational register-dependency compare: flags when a producer's rd feeds an ID source.
// Zero latency; no flow control. Reusable for forwarding checks by driving rd_valid accordingly.
module hazard_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       rd_valid,
  output logic       hit
);

  // x0 is never a real dependency
  assign hit = rd_valid & (rd != 5'd0) &
               ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline; outputs are combinational (zero latency).
// Priority: memory stall > EX redirect > load-use. Perf counters only with PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic              dmem_resp,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  output logic              imem_read,
  output logic              pc_sel,
  output logic              load_pc,
  output logic              load_if_id,
  output logic              load_id_ex,
  output logic              load_ex_mem,
  output logic              load_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  pipe_ctrl_state_t state, state_n;
  logic [1:0]       cnt, cnt_n;
  logic             load_use;
  logic             mem_stall;

  hazard_detect u_hazard (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .use_rs1  (id_use_rs1),
    .use_rs2  (id_use_rs2),
    .rd       (ex_rd),
    .rd_valid (ex_is_load),
    .hit      (load_use)
  );

  // imem_read equals rst, so the instruction-side term reduces to rst & ~imem_resp
  assign mem_stall = rst & (~imem_resp | ((dmem_read | dmem_write) & ~dmem_resp));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    imem_read   = 1'b0;
    pc_sel      = PCSEL_PLUS4;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      imem_read = 1'b1;
      if (mem_stall) begin
        state_n = MEM_WAIT;
      end else if (ex_redirect) begin
        pc_sel      = PCSEL_REDIRECT;
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_n     = RUN;
        cnt_n       = 2'd0;
      // a non-zero count means a bubble sequence is in progress (BUBBLE, or MEM_WAIT resuming it)
      end else if (cnt != 2'd0 || load_use) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_id_ex = 1'b1;
        cnt_n       = (cnt != 2'd0) ? cnt - 2'd1 : LU_INIT;
        state_n     = (cnt_n != 2'd0) ? BUBBLE : RUN;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        state_n     = RUN;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic              redirect_fire;
  logic [PERF_W-1:0] stall_q, flush_q;

  assign redirect_fire = rst & ~mem_stall & ex_redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (mem_stall)     stall_q <= stall_q + 1'b1;
      if (redirect_fire) flush_q <= flush_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (LU_BUBBLES=1 and 3) against a pending-bubble model,
// plus directed literal expectations.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       imem_resp = 1'b1;
  logic       dmem_read = 1'b0, dmem_write = 1'b0, dmem_resp = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_is_load = 1'b0, ex_redirect = 1'b0;

  logic        ir1, ps1, lp1, lf1, ld1, le1, lm1, fi1, fd1;
  logic        ir3, ps3, lp3, lf3, ld3, le3, lm3, fi3, fd3;
  logic [31:0] sc1, fc1, sc3, fc3;

  int checks = 0;
  int failures = 0;

  localparam logic [8:0] O_RST   = 9'b0_0_00000_00;
  localparam logic [8:0] O_RUN   = 9'b1_0_11111_00;
  localparam logic [8:0] O_BUB   = 9'b1_0_00111_01;
  localparam logic [8:0] O_STALL = 9'b1_0_00000_00;
  localparam logic [8:0] O_RDR   = 9'b1_1_11111_11;

  pipeline_ctrl #(.LU_BUBBLES(1), .PERF_W(32)) u1 (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_resp(dmem_resp), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .imem_read(ir1), .pc_sel(ps1),
    .load_pc(lp1), .load_if_id(lf1), .load_id_ex(ld1), .load_ex_mem(le1),
    .load_mem_wb(lm1), .flush_if_id(fi1), .flush_id_ex(fd1),
    .perf_stall_cnt(sc1), .perf_flush_cnt(fc1)
  );

  pipeline_ctrl #(.LU_BUBBLES(3), .PERF_W(32)) u3 (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_resp(dmem_resp), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .imem_read(ir3), .pc_sel(ps3),
    .load_pc(lp3), .load_if_id(lf3), .load_id_ex(ld3), .load_ex_mem(le3),
    .load_mem_wb(lm3), .flush_if_id(fi3), .flush_id_ex(fd3),
    .perf_stall_cnt(sc3), .perf_flush_cnt(fc3)
  );

  wire [8:0] o1 = {ir1, ps1, lp1, lf1, ld1, le1, lm1, fi1, fd1};
  wire [8:0] o3 = {ir3, ps3, lp3, lf3, ld3, le3, lm3, fi3, fd3};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Model: bubbles still owed, plus running perf totals
  int p1 = 0, p3 = 0;
  int ms = 0, mf = 0;

  function automatic bit m_stall();
    return !imem_resp || ((dmem_read || dmem_write) && !dmem_resp);
  endfunction

  function automatic bit m_lu();
    return ex_is_load && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic void model(input int pend, input int lu_n,
                                output logic [8:0] o, output int nxt);
    if (!rst)                 begin o = O_RST;   nxt = 0;        end
    else if (m_stall())       begin o = O_STALL; nxt = pend;     end
    else if (ex_redirect)     begin o = O_RDR;   nxt = 0;        end
    else if (pend > 0)        begin o = O_BUB;   nxt = pend - 1; end
    else if (m_lu())          begin o = O_BUB;   nxt = lu_n - 1; end
    else                      begin o = O_RUN;   nxt = 0;        end
  endfunction

  function automatic logic [31:0] perf_exp(input int v);
`ifdef PIPE_CTRL_PERF_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [8:0] o;
    int n;
    if (!rst) begin
      p1 = 0; p3 = 0; ms = 0; mf = 0;
    end else begin
      if (m_stall()) ms++;
      else if (ex_redirect) mf++;
      model(p1, 1, o, n); p1 = n;
      model(p3, 3, o, n); p3 = n;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    int n;
    model(p1, 1, e, n); chk("model_u1", 32'(o1), 32'(e));
    model(p3, 3, e, n); chk("model_u3", 32'(o3), 32'(e));
    chk("model_stall_cnt", sc1, perf_exp(ms));
    chk("model_flush_cnt", fc3, perf_exp(mf));
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic clr();
    imem_resp = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic lu_set();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    clr();
    look();
    chk("reset_u1", 32'(o1), 32'(O_RST));
    chk("reset_u3", 32'(o3), 32'(O_RST));
    chk("reset_perf", sc3, 32'd0);
    cyc(); rst = 1'b1;

    look(); chk("run_u1", 32'(o1), 32'(O_RUN)); chk("run_u3", 32'(o3), 32'(O_RUN));
    cyc(); lu_set();
    look(); chk("lu_u1", 32'(o1), 32'(O_BUB)); chk("lu_u3", 32'(o3), 32'(O_BUB));
    cyc(); clr();
    look(); chk("lu_after_u1", 32'(o1), 32'(O_RUN)); chk("lu_b2_u3", 32'(o3), 32'(O_BUB));
    cyc();
    look(); chk("lu_b3_u3", 32'(o3), 32'(O_BUB));
    cyc();
    look(); chk("lu_done_u3", 32'(o3), 32'(O_RUN));

    cyc(); lu_set(); ex_rd = 5'd0; id_rs1 = 5'd0;
    look(); chk("lu_x0_u1", 32'(o1), 32'(O_RUN));
    cyc(); lu_set(); ex_is_load = 1'b0;
    look(); chk("lu_noload_u1", 32'(o1), 32'(O_RUN));
    cyc(); lu_set(); id_use_rs1 = 1'b0; id_rs2 = 5'd5;
    look(); chk("lu_nouse_u1", 32'(o1), 32'(O_RUN));
    cyc(); clr(); ex_is_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    look(); chk("lu_rs2_u1", 32'(o1), 32'(O_BUB));
    cyc(); clr();
    look(); chk("lu_rs2_after_u1", 32'(o1), 32'(O_RUN));
    cyc(); cyc(); // u3 drains its remaining bubbles

    for (int i = 0; i < 3; i++) begin
      cyc(); imem_resp = 1'b0;
      look(); chk("imiss_u1", 32'(o1), 32'(O_STALL));
    end
    cyc(); imem_resp = 1'b1;
    look(); chk("imiss_end_u1", 32'(o1), 32'(O_RUN));
    chk("imiss_perf", sc1, perf_exp(3));

    cyc(); lu_set(); ex_redirect = 1'b1;
    look(); chk("rdr_lu_u1", 32'(o1), 32'(O_RDR)); chk("rdr_lu_u3", 32'(o3), 32'(O_RDR));
    cyc(); clr();
    look(); chk("rdr_nobub_u1", 32'(o1), 32'(O_RUN)); chk("rdr_nobub_u3", 32'(o3), 32'(O_RUN));
    chk("rdr_perf", fc1, perf_exp(1));

    for (int i = 0; i < 2; i++) begin
      cyc(); dmem_read = 1'b1; dmem_resp = 1'b0; ex_redirect = 1'b1;
      look(); chk("dmiss_rdr_u1", 32'(o1), 32'(O_STALL));
    end
    cyc(); dmem_resp = 1'b1;
    look(); chk("dmiss_rdr_go_u1", 32'(o1), 32'(O_RDR));
    cyc(); clr();
    look(); chk("dmiss_end_u3", 32'(o3), 32'(O_RUN));
    chk("dmiss_perf_stall", sc3, perf_exp(5));
    chk("dmiss_perf_flush", fc3, perf_exp(2));

    cyc(); lu_set();
    look(); chk("bub_stall_a_u3", 32'(o3), 32'(O_BUB));
    cyc(); clr(); imem_resp = 1'b0;
    look(); chk("bub_stall_b_u3", 32'(o3), 32'(O_STALL));
    cyc(); imem_resp = 1'b1;
    look(); chk("bub_resume_u1", 32'(o1), 32'(O_RUN)); chk("bub_resume_u3", 32'(o3), 32'(O_BUB));
    cyc();
    look(); chk("bub_resume2_u3", 32'(o3), 32'(O_BUB));
    cyc();
    look(); chk("bub_resume_end_u3", 32'(o3), 32'(O_RUN));

    cyc(); imem_resp = 1'b0; dmem_read = 1'b1; dmem_resp = 1'b0;
    look(); chk("both_miss_u1", 32'(o1), 32'(O_STALL));
    cyc(); imem_resp = 1'b1;
    look(); chk("both_imem_back_u1", 32'(o1), 32'(O_STALL));
    cyc(); dmem_resp = 1'b1;
    look(); chk("both_done_u1", 32'(o1), 32'(O_RUN));
    chk("both_perf", sc1, perf_exp(8));

    cyc(); clr(); lu_set();
    cyc(); clr();
    look(); chk("mid_bub_u3", 32'(o3), 32'(O_BUB));
    rst = 1'b0; #1;
    chk("async_rst_u3", 32'(o3), 32'(O_RST));
    chk("async_rst_u1", 32'(o1), 32'(O_RST));
    chk("async_rst_perf", sc3, 32'd0);
    #2 rst = 1'b1; #1;
    chk("rst_release_u3", 32'(o3), 32'(O_RUN));
    cyc();
    look(); chk("post_rst_u3", 32'(o3), 32'(O_RUN)); chk("post_rst_u1", 32'(o1), 32'(O_RUN));
    cyc();
    look(); chk("post_rst2_u3", 32'(o3), 32'(O_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
